// File: rtl/pipe_latch_skid.sv
// Inter-stage pipeline latch: valid/ready handshake, two-entry skid buffer,
// synchronous flush, bubble on empty and a saturating stall-cycle counter.
module pipe_latch_skid #(
  parameter int unsigned          DATA_W = 96,
  parameter logic [DATA_W-1:0]    BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned          CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_exception,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_exception,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic                main_exc_q, main_exc_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_exc_q, skid_exc_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                accept;
  logic                pop;

  // Entry valid bits are implied by the state: main valid in ONE/FULL, skid valid in FULL.
  assign out_valid     = (state_q != EMPTY);
  assign out_data      = out_valid ? main_data_q : BUBBLE;
  assign out_exception = out_valid & main_exc_q;
  assign in_ready      = in_ready_q;
  assign stall_count   = stall_q;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_exc_d  = main_exc_q;
    skid_data_d = skid_data_q;
    skid_exc_d  = skid_exc_q;
    stall_d     = stall_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_exc_d  = in_exception;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_data_d = in_data;
          main_exc_d  = in_exception;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_exc_d  = in_exception;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_exc_d  = skid_exc_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    // Registered ready looks at the next state, so out_ready never reaches in_ready combinationally.
    in_ready_d = (state_d != FULL);

    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
    main_data_q <= main_data_d;
    main_exc_q  <= main_exc_d;
    skid_data_q <= skid_data_d;
    skid_exc_q  <= skid_exc_d;
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Self-checking bench for pipe_latch_skid: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pipe_latch_skid;

  localparam int unsigned       DATA_W = 96;
  localparam int unsigned       CNT_W  = 4;
  localparam logic [DATA_W-1:0] BUBBLE = 96'h13;
  localparam int unsigned       SAT    = 15;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_exception;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_exception;
  logic [CNT_W-1:0]  stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of {exception, payload} with capacity 2.
  logic [DATA_W:0] m_q[$];
  bit              m_rdy = 1'b1;
  int unsigned     m_cnt = 0;

  pipe_latch_skid #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_exception  (in_exception),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_exception (out_exception),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] m_data();
    logic [DATA_W:0] e;
    if (m_q.size() == 0) return BUBBLE;
    e = m_q[0];
    return e[DATA_W-1:0];
  endfunction

  function automatic logic m_exc();
    logic [DATA_W:0] e;
    if (m_q.size() == 0) return 1'b0;
    e = m_q[0];
    return e[DATA_W];
  endfunction

  task automatic model_step();
    bit had;
    bit acc;
    had = (m_q.size() != 0);
    acc = in_valid && m_rdy;
    if (reset) begin
      m_q.delete();
      m_rdy = 1'b1;
      m_cnt = 0;
    end else begin
      if (had && !out_ready && m_cnt < SAT) m_cnt++;
      if (flush) begin
        m_q.delete();
        m_rdy = 1'b1;
      end else begin
        if (had && out_ready) void'(m_q.pop_front());
        if (acc) m_q.push_back({in_exception, in_data});
        m_rdy = (m_q.size() < 2);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_exception = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = 96'hABCD; in_exception = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL reset_out_data: got %h expected %h", out_data, BUBBLE); end
    checks++; if (out_exception !== 1'b0) begin errors++; $display("FAIL reset_out_exc: got %b expected 0", out_exception); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (stall_count !== '0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_exception = 1'b0;
    for (int unsigned i = 1; i <= 3; i++) begin
      in_data = DATA_W'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin errors++; $display("FAIL stream_data%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, DATA_W'(i)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== BUBBLE) begin errors++; $display("FAIL stream_drain: got v=%b %h expected v=0 %h", out_valid, out_data, BUBBLE); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] seen[$];
    bit acc;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'hA;
    tick();
    checks++; if (out_data !== 96'hA || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got %h rdy=%b expected a rdy=1", out_data, in_ready); end
    out_ready = 1'b0; in_data = 96'hB;
    tick();
    checks++; if (out_data !== 96'hA || in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid: got %h rdy=%b expected a rdy=0", out_data, in_ready); end
    in_data = 96'hC;
    tick();
    checks++; if (out_data !== 96'hA || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold: got %h rdy=%b expected a rdy=0", out_data, in_ready); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL bp_stall: got %0d expected 2", stall_count); end
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (out_valid) seen.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++; if (seen.size() != 3 || seen[0] !== 96'hA || seen[1] !== 96'hB || seen[2] !== 96'hC) begin
      errors++; $display("FAIL bp_order: got %0d beats expected a,b,c", seen.size());
    end
    checks++; if (out_valid !== 1'b0 || stall_count !== 4'd2) begin errors++; $display("FAIL bp_end: got v=%b stall=%0d expected v=0 stall=2", out_valid, stall_count); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h11;
    tick();
    in_data = 96'h22;
    tick();
    flush = 1'b1; in_data = 96'h77;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== BUBBLE || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full: got v=%b %h rdy=%b expected v=0 %h rdy=1", out_valid, out_data, in_ready, BUBBLE);
    end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL flush_stall: got %0d expected 2", stall_count); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop%0d: got v=%b %h expected v=0", i, out_valid, out_data); end
    end
    in_valid = 1'b1; in_data = 96'h33;
    tick();
    flush = 1'b1; in_data = 96'h44;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_one: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_drop: got v=%b %h expected v=0", out_valid, out_data); end
  endtask

  task automatic test_exception();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h55; in_exception = 1'b1;
    tick();
    checks++; if (out_exception !== 1'b1 || out_data !== 96'h55) begin errors++; $display("FAIL exc_carry: got e=%b %h expected e=1 55", out_exception, out_data); end
    in_valid = 1'b0; in_exception = 1'b0;
    tick();
    checks++; if (out_exception !== 1'b0 || out_data !== BUBBLE || out_valid !== 1'b0) begin
      errors++; $display("FAIL exc_bubble: got e=%b v=%b %h expected e=0 v=0 %h", out_exception, out_valid, out_data, BUBBLE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h9;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", stall_count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stall_count !== 4'd15 || out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush: got %0d v=%b expected 15 v=0", stall_count, out_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL sat_reset: got %0d expected 0", stall_count); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp_d;
    do_reset();
    for (int unsigned i = 0; i < 600; i++) begin
      in_valid     = ($urandom_range(9) < 7);
      out_ready    = ($urandom_range(9) < 6);
      in_data      = {$urandom, $urandom, $urandom};
      in_exception = $urandom_range(1);
      flush        = ($urandom_range(24) == 0);
      reset        = ($urandom_range(79) == 0);
      tick();
      exp_d = m_data();
      checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, out_valid, m_q.size() != 0); end
      checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", i, out_data, exp_d); end
      checks++; if (out_exception !== m_exc()) begin errors++; $display("FAIL rnd_exc@%0d: got %b expected %b", i, out_exception, m_exc()); end
      checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", i, in_ready, m_rdy); end
      checks++; if (stall_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_stall@%0d: got %0d expected %0d", i, stall_count, m_cnt); end
    end
    reset = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_exception = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_exception();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_latch_skid.md
# pipe_latch_skid

Parametrised inter-stage pipeline latch with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating stall-cycle counter. It replaces the fixed 32-bit, stall-gated latches between processor stages (e.g. execute→memory). It carries an arbitrary-width payload plus an exception flag, and presents a defined bubble value whenever it is empty. Backpressure is absorbed without a combinational ready path from downstream to upstream.

## Interface
- DATA_W, 96: payload width in bits (e.g. ALU_out, B, IR concatenated).
- BUBBLE, {DATA_W{1'b0}}: value driven on out_data while out_valid is 0 (NOP encoding).
- CNT_W, 16: width of the stall-cycle counter.
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clock.
- flush, input, 1: discard all held entries (branch mispredict / exception redirect).
- in_valid, input, 1: upstream offers in_data / in_exception.
- in_ready, output, 1: latch can accept; registered output.
- in_data, input, DATA_W: payload.
- in_exception, input, 1: exception flag travelling with the payload.
- out_valid, output, 1: out_data / out_exception hold a real entry.
- out_ready, input, 1: downstream consumes the entry this cycle.
- out_data, output, DATA_W: head payload, or BUBBLE when empty.
- out_exception, output, 1: head exception flag, 0 when empty.
- stall_count, output, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: a main entry (drives outputs) and a skid entry. Each entry holds payload, exception flag and a valid bit.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- States: EMPTY (no entries), ONE (main only), FULL (main + skid).
- EMPTY, accept → ONE. Main ← input.
- ONE:
  - accept & pop → ONE. Main ← input.
  - accept & ~pop → FULL. Skid ← input.
  - ~accept & pop → EMPTY.
  - otherwise hold.
- FULL (in_ready = 0):
  - pop → ONE. Main ← skid, skid cleared.
  - otherwise hold.
- in_ready is registered and equals "next state ≠ FULL".
- flush: next state EMPTY, in_ready ← 1, both entries invalidated. It overrides any accept or pop in the same cycle; a beat offered in the flush cycle is dropped.
- Reset has the same effect as flush, and also clears stall_count.
- Empty output: out_data = BUBBLE and out_exception = 0, so downstream decode sees a NOP.
- Payload is never modified. The exception flag is carried unchanged and does not block flow.
- stall_count increments by 1 per cycle with out_valid & ~out_ready, saturates at 2^CNT_W−1, and is not cleared by flush.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = BUBBLE
  - out_exception = 0
  - in_ready = 1
  - stall_count = 0
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready stays 1.
- Backpressure: after out_ready falls, at most one further beat is accepted (into skid); in_ready is low from the following cycle.
- Recovery: one pop in FULL raises in_ready for the next cycle. Ordering is strictly FIFO, with no loss or duplication except on flush.
- Data outputs change only on a clock edge and have no combinational path from in_* or out_ready. in_ready has no combinational path from out_ready.
- Reset or flush asserted mid-burst: outputs show the bubble from the next cycle. An accept in that same cycle is ignored.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, out_data=BUBBLE, in_ready=1, stall_count=0 after release.
- Streaming: out_ready=1, offer 0x1, 0x2, 0x3 on consecutive cycles → out_data shows 0x1, 0x2, 0x3 one cycle later on consecutive cycles, with in_ready constantly 1.
- Backpressure: stream 0xA, 0xB, 0xC and drop out_ready the cycle 0xA appears → 0xB lands in skid, in_ready=0, 0xC held upstream. Raise out_ready for 3 cycles → 0xA, 0xB, 0xC each appear once, in order. stall_count = number of stalled cycles.
- Flush in FULL with in_valid=1 → next cycle out_valid=0, out_data=BUBBLE, in_ready=1. The offered beat is not seen at the output.
- Exception carriage: accept in_data=0x55 with in_exception=1 → out_exception=1 alongside 0x55. Following bubble shows out_exception=0.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_count stops at 15. Flush leaves it at 15; reset returns it to 0.
